// File: rtl/gps_iq_log_packer_pkg.sv
// rtl/gps_iq_log_packer_pkg.sv - shared encodings and widths for the GPS IQ log packer
// Contents: FSM state codes, sample/word/count widths, busy decode helper.
package gps_iq_log_packer_pkg;

  localparam int SPW     = 4;   // samples per packed word
  localparam int SAMP_W  = 4;   // {I[1:0], Q[1:0]}
  localparam int WORD_W  = 16;  // SPW * SAMP_W
  localparam int CNT_W   = 10;  // word count / len width
  localparam int DECIM_W = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TRIG = 2'd1;
  localparam logic [1:0] ST_CAPTURE   = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  function automatic logic is_busy(input logic [1:0] st);
    return (st == ST_WAIT_TRIG) || (st == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/gps_log_decim.sv
// rtl/gps_log_decim.sv - sample decimator producing a keep strobe for every (decim+1)-th valid sample
// Ports: clk, rst (async, active-high); clr restarts the count; en = qualified sample strobe;
//        decim = kept-sample spacing minus 1; keep = this sample is kept (combinational).
module gps_log_decim
  import gps_iq_log_packer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [DECIM_W-1:0] decim,
  output logic               keep
);

  logic [DECIM_W-1:0] dc;

  // The sample seen while dc is zero is kept, so the first sample after clr is always kept.
  assign keep = en && (dc == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc <= '0;
    end else if (clr) begin
      dc <= '0;
    end else if (en) begin
      dc <= (dc == decim) ? '0 : dc + 1'b1;
    end
  end

endmodule

// File: rtl/gps_iq_log_packer.sv
// rtl/gps_iq_log_packer.sv - packs 4-bit GPS IQ samples into 16-bit logger writes with arm/trigger, decimation and word count
// Ports: clk, rst (async, active-high); arm/abort session pulses; trig_en, trig trigger qualification;
//        decim, len captured at arm; samp_vld/samp sample input; wr/dout logger write port;
//        busy (waiting or capturing), done (session complete).
module gps_iq_log_packer
  import gps_iq_log_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_en,
  input  logic              trig,
  input  logic [DECIM_W-1:0] decim,
  input  logic [CNT_W-1:0]  len,
  input  logic              samp_vld,
  input  logic [SAMP_W-1:0] samp,
  output logic              wr,
  output logic [WORD_W-1:0] dout,
  output logic              busy,
  output logic              done
);

  logic [1:0]                     state;
  logic [DECIM_W-1:0]             decim_q;
  logic [CNT_W-1:0]               len_q;
  logic [CNT_W-1:0]               wc;
  logic [1:0]                     slot;
  logic [WORD_W-SAMP_W-1:0]       acc;   // slots 0..2; slot 3 comes straight from samp

  logic start;
  logic trig_go;
  logic active;
  logic samp_en;
  logic keep;

  assign start   = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));
  assign trig_go = (state == ST_WAIT_TRIG) && trig;
  // The sample arriving with the trigger already belongs to the capture.
  assign active  = (state == ST_CAPTURE) || trig_go;
  assign samp_en = samp_vld && active && !abort;

  gps_log_decim u_decim (
    .clk   (clk),
    .rst   (rst),
    .clr   (start || abort),
    .en    (samp_en),
    .decim (decim_q),
    .keep  (keep)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      decim_q <= '0;
      len_q   <= '0;
      wc      <= '0;
      slot    <= '0;
      acc     <= '0;
      wr      <= 1'b0;
      dout    <= '0;
    end else begin
      wr <= 1'b0;
      if (abort) begin
        // Partial word is dropped; a word completing this cycle is not written.
        state <= ST_IDLE;
        slot  <= '0;
      end else begin
        if (start) begin
          decim_q <= decim;
          len_q   <= len;
          wc      <= '0;
          slot    <= '0;
          state   <= trig_en ? ST_WAIT_TRIG : ST_CAPTURE;
        end else if (trig_go) begin
          state <= ST_CAPTURE;
        end

        if (keep) begin
          if (slot == 2'(SPW - 1)) begin
            dout <= {acc, samp};
            wr   <= 1'b1;
            slot <= '0;
            // Compare before increment so len=1023 reaches DONE without wc wrapping.
            if (wc == len_q) begin
              state <= ST_DONE;
            end else begin
              wc <= wc + 1'b1;
            end
          end else begin
            case (slot)
              2'd0:    acc[11:8] <= samp;
              2'd1:    acc[7:4]  <= samp;
              default: acc[3:0]  <= samp;
            endcase
            slot <= slot + 2'd1;
          end
        end
      end
    end
  end

  assign busy = is_busy(state);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_gps_iq_log_packer.sv
// tb/tb_gps_iq_log_packer.sv - self-checking bench for gps_iq_log_packer with a session-level reference model
module tb_gps_iq_log_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm, abort, trig_en, trig, samp_vld;
  logic [3:0]  samp, decim;
  logic [9:0]  len;
  logic        wr, busy, done;
  logic [15:0] dout;

  gps_iq_log_packer dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .abort    (abort),
    .trig_en  (trig_en),
    .trig     (trig),
    .decim    (decim),
    .len      (len),
    .samp_vld (samp_vld),
    .samp     (samp),
    .wr       (wr),
    .dout     (dout),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;
  int n0;

  // Reference model: session mode 0 idle, 1 waiting for trigger, 2 capturing, 3 done.
  int          m_mode = 0;
  int          m_decim, m_len, m_vcnt, m_nib, m_words;
  logic [15:0] m_acc;
  logic [15:0] e_dout = 16'h0000;
  logic        e_wr   = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_cycle(input logic a_arm, input logic a_abort, input logic a_trig,
                             input logic a_vld, input logic [3:0] a_samp);
    e_wr = 1'b0;
    if (a_abort) begin
      m_mode = 0;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (a_arm) begin
        m_decim = int'(decim);
        m_len   = int'(len);
        m_vcnt  = 0;
        m_nib   = 0;
        m_words = 0;
        m_mode  = trig_en ? 1 : 2;
      end
    end else begin
      if (m_mode == 1 && a_trig) m_mode = 2;
      if (m_mode == 2 && a_vld) begin
        if (m_vcnt % (m_decim + 1) == 0) begin
          m_acc = {m_acc[11:0], a_samp};
          m_nib++;
          if (m_nib == 4) begin
            e_wr   = 1'b1;
            e_dout = m_acc;
            m_nib  = 0;
            m_words++;
            if (m_words == m_len + 1) m_mode = 3;
          end
        end
        m_vcnt++;
      end
    end
  endtask

  task automatic step(input logic a_arm, input logic a_abort, input logic a_trig,
                      input logic a_vld, input logic [3:0] a_samp);
    arm = a_arm; abort = a_abort; trig = a_trig; samp_vld = a_vld; samp = a_samp;
    model_cycle(a_arm, a_abort, a_trig, a_vld, a_samp);
    @(posedge clk);
    #1;
    if (wr === 1'b1) n_wr++;
    chk("wr",   {15'b0, wr},   {15'b0, e_wr});
    chk("dout", dout,          e_dout);
    chk("busy", {15'b0, busy}, {15'b0, (m_mode == 1 || m_mode == 2)});
    chk("done", {15'b0, done}, {15'b0, (m_mode == 3)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    rst = 1'b1; arm = 0; abort = 0; trig_en = 0; trig = 0; samp_vld = 0;
    samp = 0; decim = 0; len = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr",   {15'b0, wr},   16'h0000);
    chk("rst_dout", dout,          16'h0000);
    chk("rst_busy", {15'b0, busy}, 16'h0000);
    chk("rst_done", {15'b0, done}, 16'h0000);
    rst = 1'b0;
    idle(2);

    // Two words, no trigger, back-to-back samples.
    trig_en = 0; decim = 0; len = 10'd1; n0 = n_wr;
    step(1, 0, 0, 0, 4'h0);
    for (int i = 1; i <= 8; i++) step(0, 0, 0, 1, 4'(i));
    idle(2);
    chk("t1_nwr",  16'(n_wr - n0), 16'd2);
    chk("t1_dout", dout,           16'h5678);
    chk("t1_done", {15'b0, done},  16'h0001);
    chk("t1_busy", {15'b0, busy},  16'h0000);

    // Triggered capture: trig with arm ignored, arm while waiting ignored.
    trig_en = 1; decim = 0; len = 10'd0; n0 = n_wr;
    step(1, 0, 1, 1, 4'($urandom));
    for (int i = 0; i < 9; i++) step((i == 4), 0, 0, 1, 4'($urandom));
    chk("t2_prewr", 16'(n_wr - n0), 16'd0);
    step(0, 0, 1, 1, 4'hA);
    step(0, 0, 0, 1, 4'hB);
    step(0, 0, 0, 1, 4'hC);
    step(0, 0, 0, 1, 4'hD);
    idle(2);
    chk("t2_nwr",  16'(n_wr - n0), 16'd1);
    chk("t2_dout", dout,           16'hABCD);

    // Decimation by 3.
    trig_en = 0; decim = 4'd2; len = 10'd0; n0 = n_wr;
    step(1, 0, 0, 0, 4'h0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 4'(i));
    idle(2);
    chk("t3_nwr",  16'(n_wr - n0), 16'd1);
    chk("t3_dout", dout,           16'h0369);

    // Full 1024-word session, then extra samples must be ignored.
    trig_en = 0; decim = 0; len = 10'd1023; n0 = n_wr;
    step(1, 0, 0, 0, 4'h0);
    for (int i = 0; i < 4096 + 100; i++) step(0, 0, 0, 1, 4'($urandom));
    chk("t4_nwr",  16'(n_wr - n0), 16'd1024);
    chk("t4_done", {15'b0, done},  16'h0001);

    // Abort after two kept samples, then a fresh session.
    decim = 0; len = 10'd3; n0 = n_wr;
    step(1, 0, 0, 0, 4'h0);
    step(0, 0, 0, 1, 4'h1);
    step(0, 0, 0, 1, 4'h2);
    step(0, 1, 0, 1, 4'h3);
    idle(1);
    len = 10'd0;
    step(1, 0, 0, 0, 4'h0);
    step(0, 0, 0, 1, 4'hF);
    step(0, 0, 0, 1, 4'hE);
    step(0, 0, 0, 1, 4'hD);
    step(0, 0, 0, 1, 4'hC);
    idle(1);
    chk("t5_nwr",  16'(n_wr - n0), 16'd1);
    chk("t5_dout", dout,           16'hFEDC);

    // Abort coinciding with the final word's last sample: no write.
    len = 10'd0; n0 = n_wr;
    step(1, 0, 0, 0, 4'h0);
    step(0, 0, 0, 1, 4'h7);
    step(0, 0, 0, 1, 4'h7);
    step(0, 0, 0, 1, 4'h7);
    step(0, 1, 0, 1, 4'h7);
    idle(2);
    chk("t6_nwr", 16'(n_wr - n0), 16'd0);

    // Randomized sessions with gaps, triggers, stray arms and rare aborts.
    for (int s = 0; s < 8; s++) begin
      trig_en = 1'($urandom);
      decim   = 4'($urandom_range(0, 3));
      len     = 10'($urandom_range(0, 3));
      step(1, 0, 0, 0, 4'h0);
      for (int i = 0; i < 150; i++)
        step(($urandom_range(0, 99) < 2), ($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 70), 4'($urandom));
    end

    // Asynchronous reset in the middle of a capture.
    trig_en = 0; decim = 0; len = 10'd3;
    step(1, 0, 0, 0, 4'h0);
    for (int i = 1; i <= 6; i++) step(0, 0, 0, 1, 4'(i));
    chk("t7_pre_dout", dout, 16'h1234);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_wr",   {15'b0, wr},   16'h0000);
    chk("t7_rst_dout", dout,          16'h0000);
    chk("t7_rst_busy", {15'b0, busy}, 16'h0000);
    chk("t7_rst_done", {15'b0, done}, 16'h0000);
    m_mode = 0; e_dout = 16'h0000;
    @(posedge clk);
    #1;
    chk("t7_hold_wr",   {15'b0, wr},   16'h0000);
    chk("t7_hold_busy", {15'b0, busy}, 16'h0000);
    #2;
    rst = 1'b0;
    idle(1);

    // Session after reset behaves normally.
    len = 10'd0; n0 = n_wr;
    step(1, 0, 0, 0, 4'h0);
    step(0, 0, 0, 1, 4'h9);
    step(0, 0, 0, 1, 4'h8);
    step(0, 0, 0, 1, 4'h7);
    step(0, 0, 0, 1, 4'h6);
    idle(1);
    chk("t8_nwr",  16'(n_wr - n0), 16'd1);
    chk("t8_dout", dout,           16'h9876);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gps_iq_log_packer.md
# gps_iq_log_packer

Packs 4-bit GPS IQ samples (2-bit I, 2-bit Q) into 16-bit words and drives the write port of the GPS IQ capture logger (1024 x 16 buffer that stops on full). Adds arm/trigger qualification, sample decimation and a programmable word count, so one capture session yields a bounded, trigger-aligned snapshot. Sits between the GPS front-end sample strobe and the logger.

## Interface
- SPW, 4, samples per word (fixed; 4 x 4 bits = 16)
- clk  in  1  system clock; all logic single-clock
- rst  in  1  reset, asynchronous, active-high
- arm  in  1  one-cycle pulse: start a capture session
- abort  in  1  one-cycle pulse: cancel session, back to IDLE
- trig_en  in  1  1 = wait for trig after arm; 0 = start immediately
- trig  in  1  one-cycle trigger pulse (e.g. 1 ms epoch)
- decim  in  4  keep every (decim+1)-th valid sample; sampled at arm
- len  in  10  words to capture minus 1 (0..1023 -> 1..1024 words); sampled at arm
- samp_vld  in  1  input sample strobe, may be high every cycle
- samp  in  4  {I[1:0], Q[1:0]}
- wr  out  1  one-cycle write strobe to logger
- dout  out  16  packed word, valid when wr high, held until next wr
- busy  out  1  high in WAIT_TRIG and CAPTURE
- done  out  1  high in DONE

## Operation
- States: IDLE, WAIT_TRIG, CAPTURE, DONE.
- IDLE/DONE + arm: latch decim, len; clear decimation count, slot count, word count; go WAIT_TRIG if trig_en else CAPTURE. arm in WAIT_TRIG/CAPTURE ignored.
- WAIT_TRIG + trig -> CAPTURE; trig in the arm cycle is ignored (trigger must follow arm).
- In CAPTURE each samp_vld advances decimation count dc (0..decim, wraps to 0); sample kept when dc==0. First valid sample in CAPTURE (including one coincident with the WAIT_TRIG->CAPTURE trig cycle) is kept.
- Kept samples fill slots 0..3: slot 0 -> bits [15:12], slot 1 -> [11:8], slot 2 -> [7:4], slot 3 -> [3:0]. On slot 3 fill: dout <= assembled word, wr pulses, word count wc increments, slot returns to 0.
- Write with wc==len -> DONE; further samples ignored. DONE holds until arm (restart) or abort.
- abort in any state -> IDLE next cycle; partial word discarded, no wr issued; abort wins over simultaneous arm or final write (a word completing in the abort cycle is not written).
- Samples outside CAPTURE are dropped.
- Logger reset/full handling is the logger's; packer never issues more than len+1 writes per session.

## Timing
- Reset values: wr=0, dout=16'h0000, busy=0, done=0, state IDLE, all counters 0.
- wr asserted exactly one cycle after the samp_vld cycle that fills slot 3; dout updates in the same edge.
- Back-to-back samples with decim=0: one wr every 4 cycles, no stall, no loss.
- busy rises the cycle after arm; done rises the cycle after the final wr edge (same edge as state change), i.e. done and final wr are concurrent.
- len=1023: 1024 writes; wc is 10 bits and must not wrap before DONE comparison (compare before increment).
- rst mid-session: immediate return to reset values, no wr glitch.

## Structure
- Shared package: state encoding (2-bit IDLE/WAIT_TRIG/CAPTURE/DONE), SPW, sample width 4, word width 16, count width 10.
- One sub-module natural: gps_log_decim (dc counter, keep strobe, clear input); FSM, packing shift register and word counter stay in top.

## Test plan
- trig_en=0, decim=0, len=1, samples 0x1,0x2,...,0x8 on consecutive cycles -> wr twice, dout 0x1234 then 0x5678, done high with second wr, busy low after.
- trig_en=1, decim=0, len=0, samples streaming, trig at cycle 10 with sample 0xA, then 0xB,0xC,0xD -> single wr dout 0xABCD; no wr before trig.
- decim=2, len=0, samples 0..11 -> kept 0,3,6,9 -> dout 0x0369.
- len=1023, decim=0, continuous random samples -> exactly 1024 wr, done after 1024th, no further wr for 100 extra samples.
- abort after 2 kept samples, then arm with len=0 and samples 0xF,0xE,0xD,0xC -> no wr from first session, dout 0xFEDC.
- rst asserted mid-CAPTURE (async, between edges) -> outputs zero immediately; arm in WAIT_TRIG ignored; trig coincident with arm ignored.
